// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-side PC/branch unit.
package pc_pkg;
  typedef enum logic [2:0] {NE, EQ, GT, LT, GE, LE, OV, UN} cond_e;
  typedef enum logic {RUN, HALT} state_e;
  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;
endpackage

// File: rtl/pc_cond_eval.sv
// pc_cond_eval: resolves a 3-bit condition code against the {N,V,Z} flags.
module pc_cond_eval
  import pc_pkg::*;
(
  input  logic [2:0] cond_i,
  input  logic [2:0] flags_i,
  output logic       take_o
);
  logic z, v, n;
  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];
  assign n = flags_i[FLAG_N];
  always_comb begin
    take_o = 1'b0;
    case (cond_e'(cond_i))
      NE:      take_o = ~z;
      EQ:      take_o = z;
      GT:      take_o = ~z & ~n;
      LT:      take_o = n;
      GE:      take_o = z | ~n;
      LE:      take_o = n | z;
      OV:      take_o = v;
      UN:      take_o = 1'b1;
      default: take_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: PC register, flag register, next-PC selection, halt FSM,
// post-branch flush pulse and saturating taken-branch counter.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              OFF_W    = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_valid,
  input  logic             br_mode,
  input  logic [2:0]       cond,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  reg_target,
  input  logic [2:0]       flag_we,
  input  logic [2:0]       flags_in,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus,
  output logic [2:0]       flags,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt
);
  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d, off_ext, target;
  logic [2:0]       flags_q, flags_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             take, run, go, taken;
  pc_cond_eval u_cond (
    .cond_i (cond),
    .flags_i(flags_q),
    .take_o (take)
  );
  assign pc_plus = pc_q + PC_W'(2);
  assign off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  // offset counts 16-bit instruction words, so scale to bytes
  assign target  = br_mode ? reg_target : pc_plus + {off_ext[PC_W-2:0], 1'b0};
  assign run     = state_q == RUN;
  assign go      = run & ~stall;
  assign taken   = go & ~halt & br_valid & take;
  always_comb begin
    state_d = (go & halt) ? HALT : state_q;
    pc_d    = (!go || halt) ? pc_q : taken ? target : pc_plus;
    flush_d = taken;
    cnt_d   = (taken && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    flags_d = run ? ((flags_q & ~flag_we) | (flags_in & flag_we)) : flags_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flags_q <= '0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end
  assign pc        = pc_q;
  assign flags     = flags_q;
  assign flush     = flush_q;
  assign halted    = state_q == HALT;
  assign taken_cnt = cnt_q;
endmodule
